prog_mem: RTL and testbench
===========================

# prog_mem

Loadable, parametrised program memory for the microcomputer, the next generation of the fixed-content instruction ROM. It holds up to DEPTH instructions of DATA_WIDTH bits and serves the CPU fetch port with a registered one-cycle read. The contents are written at run time by a byte-stream loader state machine, for example fed by a UART bootloader. Reads at or beyond the loaded program size return zero and raise an address error.

## Interface
Parameters:
- DATA_WIDTH, 24: instruction width. Must be a multiple of 8. BPW = DATA_WIDTH/8 bytes per word.
- ADDR_WIDTH, 8: fetch address width.
- DEPTH, 256: number of words. Must satisfy 1 ≤ DEPTH ≤ 2^ADDR_WIDTH.

Ports:
- clock, in, 1: 50 MHz system clock. Single clock domain.
- reset_s2_n, in, 1: synchronised reset. Asynchronous, active-low.
- address, in, ADDR_WIDTH: CPU fetch address.
- data_out, out, DATA_WIDTH: registered instruction.
- addr_error, out, 1: registered; high when the last sampled address was at or beyond program_size, or a fetch was attempted during a load.
- load_start, in, 1: single-cycle request to begin a load. Sampled only in IDLE.
- load_len, in, ADDR_WIDTH+1: number of words to load. Sampled together with load_start.
- load_byte, in, 8: stream byte.
- load_valid, in, 1: load_byte is valid.
- load_ready, out, 1: the block accepts a byte. A byte transfers when load_valid && load_ready.
- loading, out, 1: high while in state LOAD.
- load_done, out, 1: one-cycle pulse when a load completes.
- load_error, out, 1: one-cycle pulse when load_len is illegal.
- program_size, out, ADDR_WIDTH+1: number of valid words.

## Operation
- Reset values: all outputs 0; state IDLE; program_size 0. Memory array contents are not reset and are don't-care; program_size gating makes them unobservable.
- States:
  - IDLE: if load_start and 1 ≤ load_len ≤ DEPTH, go to LOAD. Latch load_len, clear the word counter, the byte counter and program_size. If load_start with an illegal load_len, pulse load_error and stay in IDLE; program_size is unchanged.
  - LOAD: load_ready = 1. Each accepted byte shifts into the assembly register, big-endian: the first byte is bits [DATA_WIDTH-1:DATA_WIDTH-8], i.e. the op code. On the BPW-th byte, write the completed word to mem[word counter], increment the word counter and reset the byte counter. When the written word is number load_len, go to DONE.
  - DONE: one cycle. program_size <= latched load_len, load_done = 1, load_ready = 0, then return to IDLE.
- load_start during LOAD or DONE is ignored. There is no abort path; reset is the abort.
- Fetch, every cycle:
  - In IDLE or DONE, if address < program_size: data_out <= mem[address], addr_error <= 0.
  - In IDLE or DONE, otherwise: data_out <= 0, addr_error <= 1. Out-of-range is data_out = 0, not hold.
  - During LOAD: data_out <= 0, addr_error <= 1. The CPU must be held by the system while loading.
- Arithmetic: the word counter is ADDR_WIDTH+1 bits, so DEPTH = 2^ADDR_WIDTH never wraps. The byte counter is ceil(log2(BPW)) bits, or 1 bit minimum, and wraps at BPW.
- The address comparison is unsigned. It is zero-extended to ADDR_WIDTH+1 bits before comparing with program_size.

## Timing
- Read latency 1 cycle: the address presented at edge N appears on data_out/addr_error after edge N.
- load_ready rises the cycle after load_start is accepted and is combinational from state only. It never depends on load_valid.
- A word is written on the edge that accepts its last byte. load_done is high in the cycle after the final byte is accepted.
- Fetches see the new program from the edge where DONE is entered. The first valid read data appears one cycle later.
- Gaps in load_valid stall the loader indefinitely with no timeout. The state and partial word are held.
- An asynchronous reset mid-load returns to IDLE with program_size 0. All reads then return 0 with addr_error = 1 until a complete load finishes. load_done is never pulsed for the aborted load.

## Test plan
- Reset, no load; address 0x00 -> data_out 0x000000, addr_error 1, program_size 0.
- load_start, load_len=2; bytes 01 02 03 04 05 06 with continuous valid -> load_done pulse one cycle after byte 06, program_size 2. Address 0 -> 0x010203; address 1 -> 0x040506; address 2 -> 0, addr_error 1.
- Same load with load_valid deasserted for 3 cycles between each byte -> identical contents. load_done occurs only after the sixth accepted byte.
- load_len=0, then load_len=DEPTH+1 (257) -> one load_error pulse each, loading stays 0, previous program_size retained. A load_start pulse during LOAD is ignored: the load completes with the original length.
- Reset asserted after 4 of 6 bytes -> loading 0, load_ready 0, program_size 0, no load_done. address 0 -> data_out 0, addr_error 1.
- Full load, DEPTH=256, word i = {i, ~i, 0xA5} -> address 0xFF reads 0xFF00A5. program_size 256, no wrap. Every address reads back correctly with addr_error 0.

Source files
------------

// File: rtl/prog_mem.sv
// Loadable program memory: a byte-stream loader fills the array, and the CPU fetch
// port reads it back one cycle later, with reads gated by the loaded program size.
module prog_mem #(
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 256
) (
    input  logic                  clock,
    input  logic                  reset_s2_n,
    input  logic [ADDR_WIDTH-1:0] address,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  addr_error,
    input  logic                  load_start,
    input  logic [ADDR_WIDTH:0]   load_len,
    input  logic [7:0]            load_byte,
    input  logic                  load_valid,
    output logic                  load_ready,
    output logic                  loading,
    output logic                  load_done,
    output logic                  load_error,
    output logic [ADDR_WIDTH:0]   program_size
);

    localparam int BPW = DATA_WIDTH / 8;
    localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [BCW-1:0]      LAST_BYTE = BCW'(BPW - 1);
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH + 1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_DONE
    } state_t;

    state_t                state;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   len_q;
    logic [ADDR_WIDTH:0]   word_cnt;
    logic [BCW-1:0]        byte_cnt;
    logic [DATA_WIDTH-1:0] asm_q;
    logic [DATA_WIDTH-1:0] asm_next;
    logic                  byte_fire;
    logic                  word_fire;
    logic                  last_word;
    logic                  len_ok;

    // Big-endian assembly: earlier bytes shift toward the MSBs.
    assign asm_next   = (asm_q << 8) | DATA_WIDTH'(load_byte);
    assign byte_fire  = (state == S_LOAD) && load_valid;
    assign word_fire  = byte_fire && (byte_cnt == LAST_BYTE);
    assign last_word  = (word_cnt + (ADDR_WIDTH + 1)'(1)) == len_q;
    assign len_ok     = (load_len != '0) && (load_len <= DEPTH_W);

    assign load_ready = (state == S_LOAD);
    assign loading    = (state == S_LOAD);
    assign load_done  = (state == S_DONE);

    // NOTE: the array has no reset; program_size gating hides stale contents,
    // and leaving it unreset lets it map onto block RAM.
    always_ff @(posedge clock) begin
        if (word_fire) begin
            mem[word_cnt[ADDR_WIDTH-1:0]] <= asm_next;
        end
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            state        <= S_IDLE;
            len_q        <= '0;
            word_cnt     <= '0;
            byte_cnt     <= '0;
            asm_q        <= '0;
            program_size <= '0;
            load_error   <= 1'b0;
        end else begin
            load_error <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (load_start) begin
                        if (len_ok) begin
                            state        <= S_LOAD;
                            len_q        <= load_len;
                            word_cnt     <= '0;
                            byte_cnt     <= '0;
                            asm_q        <= '0;
                            program_size <= '0;
                        end else begin
                            load_error <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (byte_fire) begin
                        asm_q <= asm_next;
                        if (word_fire) begin
                            byte_cnt <= '0;
                            word_cnt <= word_cnt + (ADDR_WIDTH + 1)'(1);
                            // Size becomes visible on DONE entry so the DONE cycle can fetch.
                            if (last_word) begin
                                state        <= S_DONE;
                                program_size <= len_q;
                            end
                        end else begin
                            byte_cnt <= byte_cnt + BCW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_s2_n) begin
        if (!reset_s2_n) begin
            data_out   <= '0;
            addr_error <= 1'b0;
        end else if ((state != S_LOAD) && ({1'b0, address} < program_size)) begin
            data_out   <= mem[address];
            addr_error <= 1'b0;
        end else begin
            data_out   <= '0;
            addr_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_prog_mem.sv
// Directed bench for prog_mem: reset, short loads with and without valid gaps,
// illegal lengths, mid-load reset and a full-depth load with readback.
module tb_prog_mem;

    localparam int DW    = 24;
    localparam int AW    = 8;
    localparam int DEPTH = 256;

    logic          clock = 1'b0;
    logic          reset_s2_n;
    logic [AW-1:0] address;
    logic [DW-1:0] data_out;
    logic          addr_error;
    logic          load_start;
    logic [AW:0]   load_len;
    logic [7:0]    load_byte;
    logic          load_valid;
    logic          load_ready;
    logic          loading;
    logic          load_done;
    logic          load_error;
    logic [AW:0]   program_size;

    int checks   = 0;
    int failures = 0;

    always #10 clock = ~clock;

    prog_mem #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
        .clock        (clock),
        .reset_s2_n   (reset_s2_n),
        .address      (address),
        .data_out     (data_out),
        .addr_error   (addr_error),
        .load_start   (load_start),
        .load_len     (load_len),
        .load_byte    (load_byte),
        .load_valid   (load_valid),
        .load_ready   (load_ready),
        .loading      (loading),
        .load_done    (load_done),
        .load_error   (load_error),
        .program_size (program_size)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic fetch(input logic [AW-1:0] a, input logic [DW-1:0] exp_d,
                         input logic exp_e, input string tag);
        address = a;
        step();
        check({tag, "_data"}, 32'(data_out), 32'(exp_d));
        check({tag, "_err"}, 32'(addr_error), 32'(exp_e));
    endtask

    // Runs a complete load; mid_start_at >= 0 pulses an extra load_start (len 1) with that byte.
    task automatic do_load(input int len, input byte unsigned bytes[$], input int gap,
                           input int mid_start_at, input string tag);
        int early;
        early      = 0;
        load_len   = (AW + 1)'(len);
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check({tag, "_loading"}, 32'(loading), 32'd1);
        check({tag, "_ready"}, 32'(load_ready), 32'd1);
        for (int i = 0; i < bytes.size(); i++) begin
            repeat (gap) begin
                load_valid = 1'b0;
                step();
                if (load_done) early++;
            end
            load_byte  = bytes[i];
            load_valid = 1'b1;
            if (i == mid_start_at) begin
                load_start = 1'b1;
                load_len   = (AW + 1)'(1);
            end
            step();
            load_start = 1'b0;
            if ((i != bytes.size() - 1) && load_done) early++;
        end
        load_valid = 1'b0;
        check({tag, "_done"}, 32'(load_done), 32'd1);
        check({tag, "_early_done"}, 32'(early), 32'd0);
        check({tag, "_size"}, 32'(program_size), 32'(len));
        check({tag, "_ready_off"}, 32'(load_ready), 32'd0);
        step();
        check({tag, "_done_pulse"}, 32'(load_done), 32'd0);
    endtask

    initial begin
        byte unsigned q[$];

        reset_s2_n = 1'b0;
        address    = '0;
        load_start = 1'b0;
        load_len   = '0;
        load_byte  = '0;
        load_valid = 1'b0;
        step();
        step();
        check("rst_data", 32'(data_out), 32'h0);
        check("rst_err", 32'(addr_error), 32'h0);
        check("rst_size", 32'(program_size), 32'h0);
        check("rst_loading", 32'(loading), 32'h0);
        check("rst_ready", 32'(load_ready), 32'h0);
        reset_s2_n = 1'b1;
        fetch(8'h00, 24'h0, 1'b1, "empty_a0");

        q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        do_load(2, q, 0, -1, "ld2");
        fetch(8'h00, 24'h010203, 1'b0, "ld2_a0");
        fetch(8'h01, 24'h040506, 1'b0, "ld2_a1");
        fetch(8'h02, 24'h000000, 1'b1, "ld2_a2");

        do_load(2, q, 3, -1, "gap");
        fetch(8'h00, 24'h010203, 1'b0, "gap_a0");
        fetch(8'h01, 24'h040506, 1'b0, "gap_a1");

        load_len   = 9'd0;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("len0_err", 32'(load_error), 32'd1);
        check("len0_loading", 32'(loading), 32'd0);
        step();
        check("len0_err_pulse", 32'(load_error), 32'd0);
        check("len0_size", 32'(program_size), 32'd2);
        load_len   = 9'd257;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        check("len257_err", 32'(load_error), 32'd1);
        check("len257_loading", 32'(loading), 32'd0);
        step();
        check("len257_err_pulse", 32'(load_error), 32'd0);
        check("len257_size", 32'(program_size), 32'd2);
        fetch(8'h01, 24'h040506, 1'b0, "len257_a1");

        q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16};
        do_load(2, q, 0, 1, "midstart");
        fetch(8'h00, 24'h111213, 1'b0, "midstart_a0");
        fetch(8'h01, 24'h141516, 1'b0, "midstart_a1");

        load_len   = 9'd2;
        load_start = 1'b1;
        step();
        load_start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            load_byte  = 8'(8'h21 + i);
            load_valid = 1'b1;
            step();
        end
        load_valid = 1'b0;
        reset_s2_n = 1'b0;
        #1;
        check("abort_loading", 32'(loading), 32'd0);
        check("abort_ready", 32'(load_ready), 32'd0);
        check("abort_size", 32'(program_size), 32'd0);
        check("abort_done", 32'(load_done), 32'd0);
        step();
        reset_s2_n = 1'b1;
        step();
        check("abort_done_after", 32'(load_done), 32'd0);
        fetch(8'h00, 24'h0, 1'b1, "abort_a0");
        fetch(8'h01, 24'h0, 1'b1, "abort_a1");

        q = {};
        for (int i = 0; i < DEPTH; i++) begin
            q.push_back(8'(i));
            q.push_back(8'(~i));
            q.push_back(8'hA5);
        end
        do_load(DEPTH, q, 0, -1, "full");
        fetch(8'hFF, 24'hFF00A5, 1'b0, "full_aFF");
        check("full_size", 32'(program_size), 32'd256);
        for (int i = 0; i < DEPTH; i++) begin
            logic [7:0] a;
            logic [7:0] na;
            a  = 8'(i);
            na = ~a;
            fetch(a, {a, na, 8'hA5}, 1'b0, $sformatf("full_a%0d", i));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
